tt_ternary_ctrl: RTL and testbench

Job sequencer for the ternary weight loader and the ternary matmul datapath. It accepts a job command, sets the loader configuration, and gates the shared input bus into the loader for exactly one weight image. It then forwards activation beats to the matmul, waits out the matmul pipeline, and reports completion or error. It sits between the tile pin interface and the loader/matmul pair.

---
 rtl/tt_ternary_pkg.sv | 34 +++
 rtl/tt_ternary_ctrl.sv | 161 ++++++++++++++++
 tb/tb_tt_ternary_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_ternary_pkg.sv
// Shared types and field layout for the ternary job sequencer.
package tt_ternary_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOAD    = 2'd1,
      S_COMPUTE = 2'd2,
      S_DRAIN   = 2'd3
   } state_e;

   localparam int MAX_IN_LEN_DEF  = 16;
   localparam int MAX_OUT_LEN_DEF = 8;

   // cmd_param layout: {in_len-1, out_len-1}
   localparam int OUT_LEN_LSB = 0;
   localparam int OUT_LEN_W   = 3;
   localparam int IN_LEN_LSB  = 3;
   localparam int IN_LEN_W    = 4;
   localparam int PARAM_W     = IN_LEN_W + OUT_LEN_W;

   // Shared beat counter must reach 256 activation vectors
   localparam int CNT_W = 9;

   // Beats in one weight image: each row is an MSB beat followed by an LSB beat
   function automatic logic [CNT_W-1:0] load_beats(input logic [OUT_LEN_W-1:0] out_len_m1);
      return CNT_W'({out_len_m1, 1'b0}) + CNT_W'(2);
   endfunction

   // Activation vectors per job; an encoded 0 stands for 256
   function automatic logic [CNT_W-1:0] nvec_beats(input logic [7:0] nvec);
      return {(nvec == 8'd0), nvec};
   endfunction

endpackage

// File: rtl/tt_ternary_ctrl.sv
// Job sequencer: gates one weight image into the loader, streams activation
// beats to the matmul, waits out the matmul pipeline, then reports done/err.
module tt_ternary_ctrl
   import tt_ternary_pkg::*;
#(
   parameter int MAX_IN_LEN  = MAX_IN_LEN_DEF,
   parameter int MAX_OUT_LEN = MAX_OUT_LEN_DEF,
   parameter int MM_LATENCY  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               cmd_start,
   input  logic [PARAM_W-1:0] cmd_param,
   input  logic [7:0]         cmd_nvec,
   input  logic               cmd_skip_load,
   input  logic               in_valid,
   output logic               ld_ena,
   output logic [PARAM_W-1:0] ld_param,
   input  logic               ld_done,
   output logic               mm_valid,
   output logic               mm_last,
   output logic               busy,
   output logic               done,
   output logic               err
);

   // The field layout and counter width are sized for these limits
   if (MM_LATENCY < 1 || MAX_OUT_LEN > (1 << OUT_LEN_W) || MAX_IN_LEN > (1 << IN_LEN_W) ||
       IN_LEN_LSB != OUT_LEN_LSB + OUT_LEN_W) begin : g_param_check
      $error("tt_ternary_ctrl: unsupported parameter combination");
   end

   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(MM_LATENCY - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         nvec_q, nvec_d;
   logic [PARAM_W-1:0] param_q, param_d;
   logic               flag_q, flag_d;
   logic               busy_q, done_q, err_q;
   logic               done_d, err_d;
   logic               beat, load_last, comp_last;

   assign beat      = in_valid & ena;
   assign load_last = (cnt_q + CNT_W'(1)) == load_beats(param_q[OUT_LEN_LSB +: OUT_LEN_W]);
   assign comp_last = (cnt_q + CNT_W'(1)) == nvec_beats(nvec_q);

   assign ld_param = param_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

   // State, shared counter, job latches and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         nvec_q  <= '0;
         param_q <= '0;
         flag_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         nvec_q  <= nvec_d;
         param_q <= param_d;
         flag_q  <= flag_d;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Next-state, counter and pulse decisions
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      nvec_d  = nvec_q;
      param_d = param_q;
      flag_d  = flag_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_start && ena) begin
               param_d = cmd_param;
               nvec_d  = cmd_nvec;
               cnt_d   = '0;
               flag_d  = 1'b0;
               state_d = cmd_skip_load ? S_COMPUTE : S_LOAD;
            end
         end
         S_LOAD: begin
            flag_d = flag_q | ld_done;
            if (beat) begin
               if (load_last) begin
                  cnt_d = '0;
                  if (flag_q || ld_done) begin
                     state_d = S_COMPUTE;
                  end else begin
                     err_d   = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (cnt_q != '0) begin
               // The loader cannot stall once a load is open
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         S_COMPUTE: begin
            if (beat) begin
               if (comp_last) begin
                  cnt_d   = '0;
                  state_d = S_DRAIN;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (ena) begin
               if (cnt_q >= DRAIN_LAST) begin
                  cnt_d   = '0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A request while busy is rejected; done takes precedence so the pulses never overlap
      if (cmd_start && state_q != S_IDLE && !done_d) begin
         err_d = 1'b1;
      end
   end

   // Beat strobes follow in_valid combinationally so data and enable share a cycle
   always_comb begin
      ld_ena   = 1'b0;
      mm_valid = 1'b0;
      mm_last  = 1'b0;
      unique case (state_q)
         S_LOAD:    ld_ena = beat;
         S_COMPUTE: begin
            mm_valid = beat;
            mm_last  = beat & comp_last;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tt_ternary_ctrl.sv
// Self-checking bench for tt_ternary_ctrl: scoreboard of expected
// mm_last/done/err events plus direct output checks.
module tb_tt_ternary_ctrl;

   localparam int K_LAST = 1;
   localparam int K_DONE = 2;
   localparam int K_ERR  = 3;

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   logic       clk, rst_n, ena, cmd_start, cmd_skip_load, in_valid, ld_done;
   logic [6:0] cmd_param;
   logic [7:0] cmd_nvec;
   logic       ld_ena, mm_valid, mm_last, busy, done, err;
   logic [6:0] ld_param;

   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   ld_cnt = 0;
   int   mm_cnt = 0;
   ev_t  exp_q[$];

   tt_ternary_ctrl #(.MAX_IN_LEN(16), .MAX_OUT_LEN(8), .MM_LATENCY(2)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .cmd_start(cmd_start),
      .cmd_param(cmd_param), .cmd_nvec(cmd_nvec), .cmd_skip_load(cmd_skip_load),
      .in_valid(in_valid), .ld_ena(ld_ena), .ld_param(ld_param), .ld_done(ld_done),
      .mm_valid(mm_valid), .mm_last(mm_last), .busy(busy), .done(done), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic sb_push(input int kind, input int at);
      ev_t e;
      e.kind = kind;
      e.cyc  = at;
      exp_q.push_back(e);
   endtask

   task automatic sb_pop(input int kind);
      ev_t e;
      if (exp_q.size() == 0) begin
         check_eq("sb_unexpected_event", kind, 0);
      end else begin
         e = exp_q.pop_front();
         check_eq("sb_kind", kind, e.kind);
         check_eq("sb_cycle", cyc, e.cyc);
      end
   endtask

   // Monitor: count strobes and retire scoreboard events away from the active edge
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (ld_ena)   ld_cnt++;
         if (mm_valid) mm_cnt++;
         if (mm_last)  sb_pop(K_LAST);
         if (done)     sb_pop(K_DONE);
         if (err)      sb_pop(K_ERR);
         if (done || err) check_eq("done_err_excl", int'(done & err), 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_sb(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check_eq("sb_timeout", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic start_job(input logic [6:0] p, input logic [7:0] nv, input logic skip);
      cmd_start = 1'b1; cmd_param = p; cmd_nvec = nv; cmd_skip_load = skip;
      tick();
      cmd_start = 1'b0;
   endtask

   initial begin
      int base_ld, base_mm, c;
      rst_n = 1'b0; ena = 1'b1; cmd_start = 1'b0; cmd_param = '0; cmd_nvec = '0;
      cmd_skip_load = 1'b0; in_valid = 1'b1; ld_done = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_ld_ena", int'(ld_ena), 0);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_ld_param", int'(ld_param), 0);
      check_eq("rst_outs", int'({mm_valid, mm_last, done, err}), 0);
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      // Full load of 8 rows, ld_done one beat early, then 3 vectors with a gap
      start_job(7'h7F, 8'd3, 1'b0);
      check_eq("t1_busy", int'(busy), 1);
      check_eq("t1_ld_param", int'(ld_param), 'h7F);
      base_ld = ld_cnt;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         ld_done  = (i == 14);
         tick();
      end
      in_valid = 1'b0; ld_done = 1'b0;
      check_eq("t1_ld_beats", ld_cnt - base_ld, 16);
      check_eq("t1_busy_compute", int'(busy), 1);
      base_mm = mm_cnt;
      in_valid = 1'b1; tick();
      in_valid = 1'b0; tick();
      in_valid = 1'b1; tick();
      in_valid = 1'b1; sb_push(K_LAST, cyc); sb_push(K_DONE, cyc + 3); tick();
      in_valid = 1'b0;
      wait_sb(10);
      check_eq("t1_mm_beats", mm_cnt - base_mm, 3);
      check_eq("t1_busy_end", int'(busy), 0);

      // Gap after first of two beats aborts the load
      start_job(7'h00, 8'd1, 1'b0);
      in_valid = 1'b1; tick();
      in_valid = 1'b0; sb_push(K_ERR, cyc + 1); tick();
      check_eq("t2_busy", int'(busy), 0);
      check_eq("t2_done", int'(done), 0);
      tick();
      check_eq("t2_sb_empty", exp_q.size(), 0);

      // Full image without ld_done is rejected on the final beat
      start_job(7'h03, 8'd1, 1'b0);
      base_ld = ld_cnt;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         if (i == 7) sb_push(K_ERR, cyc + 1);
         tick();
      end
      in_valid = 1'b0;
      check_eq("t3_busy", int'(busy), 0);
      check_eq("t3_ld_beats", ld_cnt - base_ld, 8);
      tick();
      in_valid = 1'b1;
      @(negedge clk);
      check_eq("t3_idle_ld_ena", int'(ld_ena), 0);
      check_eq("t3_idle_mm_valid", int'(mm_valid), 0);
      tick();
      in_valid = 1'b0;
      check_eq("t3_sb_empty", exp_q.size(), 0);

      // Skip load with nvec=0 streams 256 vectors
      start_job(7'h11, 8'd0, 1'b1);
      base_mm = mm_cnt;
      for (int i = 0; i < 256; i++) begin
         in_valid = 1'b1;
         if (i == 255) begin
            sb_push(K_LAST, cyc);
            sb_push(K_DONE, cyc + 3);
         end
         tick();
      end
      in_valid = 1'b0;
      wait_sb(10);
      check_eq("t4_mm_beats", mm_cnt - base_mm, 256);
      check_eq("t4_busy_end", int'(busy), 0);

      // Rejected start during COMPUTE, ena freeze in COMPUTE and DRAIN
      start_job(7'h22, 8'd4, 1'b1);
      base_mm = mm_cnt;
      in_valid = 1'b1; tick();
      in_valid = 1'b1; tick();
      in_valid = 1'b0; cmd_start = 1'b1; sb_push(K_ERR, cyc + 1); tick();
      cmd_start = 1'b0;
      check_eq("t5_busy_after_err", int'(busy), 1);
      ena = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      check_eq("t5_frozen_mm_valid", int'(mm_valid), 0);
      tick();
      ena = 1'b1; in_valid = 1'b1; tick();
      in_valid = 1'b1; c = cyc; sb_push(K_LAST, c); tick();
      in_valid = 1'b0; ena = 1'b0;
      repeat (5) tick();
      check_eq("t5_busy_frozen", int'(busy), 1);
      ena = 1'b1; sb_push(K_DONE, c + 8);
      wait_sb(12);
      check_eq("t5_mm_beats", mm_cnt - base_mm, 4);

      // Asynchronous reset in the middle of a load, then a clean job
      start_job(7'h07, 8'd1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         tick();
      end
      #1;
      check_eq("t6_ld_ena_before", int'(ld_ena), 1);
      rst_n = 1'b0;
      #1;
      check_eq("t6_rst_ld_ena", int'(ld_ena), 0);
      check_eq("t6_rst_busy", int'(busy), 0);
      check_eq("t6_rst_ld_param", int'(ld_param), 0);
      check_eq("t6_rst_outs", int'({mm_valid, mm_last, done, err}), 0);
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      start_job(7'h28, 8'd1, 1'b0);
      check_eq("t6_ld_param", int'(ld_param), 'h28);
      in_valid = 1'b1; tick();
      in_valid = 1'b1; ld_done = 1'b1; tick();
      ld_done = 1'b0;
      in_valid = 1'b1; sb_push(K_LAST, cyc); sb_push(K_DONE, cyc + 3); tick();
      in_valid = 1'b0;
      wait_sb(10);
      check_eq("t6_busy_end", int'(busy), 0);

      tick();
      check_eq("final_sb_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
